// File: rtl/enet_tx_sched_if.sv
// MAC-engine side of the TX frame scheduler: frame start handshake,
// frame type, completion and abort.
interface enet_tx_sched_if;
    logic       mac_start_valid;
    logic       mac_start_ready;
    logic [1:0] mac_type;
    logic       mac_done;
    logic       mac_abort;

    // Scheduler side
    modport master (
        output mac_start_valid,
        output mac_type,
        output mac_abort,
        input  mac_start_ready,
        input  mac_done
    );

    // MAC engine side
    modport slave (
        input  mac_start_valid,
        input  mac_type,
        input  mac_abort,
        output mac_start_ready,
        output mac_done
    );
endinterface

// File: rtl/enet_tx_sched.sv
// Transmit frame scheduler: picks pause / zero-pause / data frames in fixed
// priority, applies graceful-stop and peer-pause blocking, times the
// inter-frame gap and returns single-cycle start acknowledges upstream.
module enet_tx_sched #(
    parameter int IFG_CYC = 24,
    parameter int CNT_W   = 16
) (
    input  logic             tx_clk,
    input  logic             rst,
    input  logic             i_ether_en,
    input  logic             i_gts,
    input  logic             i_rfc_pause,
    input  logic             i_tfc_pause,
    input  logic             i_pause_send,
    input  logic             i_pause_send_zero,
    input  logic             i_data_req,
    output logic             o_data_gnt,
    output logic             o_pause_mac_send,
    output logic             o_pause_mac_send_zero,
    output logic             o_tx_mac_stop,
    output logic [CNT_W-1:0] o_stat_frames,
    enet_tx_sched_if.master  mac
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SEND = 2'd2, IFG = 2'd3} state_t;

    localparam logic [1:0] T_DATA  = 2'b00;
    localparam logic [1:0] T_PAUSE = 2'b01;
    localparam logic [1:0] T_ZERO  = 2'b10;

    // Gap counter only needs to hold IFG_CYC-1.
    localparam int               IFG_W    = (IFG_CYC > 1) ? $clog2(IFG_CYC) : 1;
    localparam logic [IFG_W-1:0] IFG_LOAD = IFG_W'(IFG_CYC - 1);

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_type;
    logic [IFG_W-1:0]   r_ifg_cnt;
    logic [CNT_W-1:0]   r_stat;
    logic               r_stop;
    logic               r_abort;

    logic               w_p;
    logic               w_z;
    logic               w_d;
    logic [1:0]         w_sel_type;
    logic               w_hs;
    logic               w_ifg_load;

    assign w_p = (i_pause_send | i_tfc_pause) & ~i_gts;
    assign w_z = i_pause_send_zero & ~i_gts;
    assign w_d = i_data_req & ~i_gts & ~i_rfc_pause;
    assign w_sel_type = w_p ? T_PAUSE : (w_z ? T_ZERO : T_DATA);

    // A start is only accepted while the MAC is enabled; dropping ether_en in
    // REQ withdraws the start without an ack or count.
    assign w_hs = (r_state == REQ) & mac.mac_start_ready & i_ether_en;

    assign mac.mac_start_valid   = (r_state == REQ);
    assign mac.mac_type          = r_type;
    assign mac.mac_abort         = r_abort;
    assign o_data_gnt            = w_hs & (r_type == T_DATA);
    assign o_pause_mac_send      = w_hs & (r_type == T_PAUSE);
    assign o_pause_mac_send_zero = w_hs & (r_type == T_ZERO);
    assign o_tx_mac_stop         = r_stop;
    assign o_stat_frames         = r_stat;

    // Next-state logic. The gap is IFG cycles plus the one IDLE evaluation
    // cycle, so IFG is left as the counter steps from 1 to 0.
    always_comb begin
        w_next     = r_state;
        w_ifg_load = 1'b0;
        case (r_state)
            IDLE: if (i_ether_en & (w_p | w_z | w_d)) w_next = REQ;
            REQ: begin
                if (!i_ether_en) w_next = IDLE;
                else if (w_hs)   w_next = SEND;
            end
            SEND: begin
                if (!i_ether_en || mac.mac_done) begin
                    w_ifg_load = 1'b1;
                    w_next     = (IFG_CYC > 1) ? IFG : IDLE;
                end
            end
            IFG:     if (r_ifg_cnt <= IFG_W'(1)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge tx_clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Frame type latch, gap counter, statistics, stop and abort flags.
    always_ff @(posedge tx_clk) begin
        if (rst) begin
            r_type    <= T_DATA;
            r_ifg_cnt <= '0;
            r_stat    <= '0;
            r_stop    <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            if (r_state == IDLE && w_next == REQ) r_type <= w_sel_type;
            if (w_ifg_load)                       r_ifg_cnt <= IFG_LOAD;
            else if (r_state == IFG && r_ifg_cnt != '0) r_ifg_cnt <= r_ifg_cnt - 1'b1;
            if (w_hs) r_stat <= r_stat + 1'b1;
            r_stop  <= (i_gts | i_rfc_pause) & (r_state == IDLE);
            // A frame that finishes in the same cycle needs no abort.
            r_abort <= (r_state == SEND) & ~i_ether_en & ~mac.mac_done;
        end
    end

endmodule

// File: tb/tb_enet_tx_sched.sv
// Directed bench for enet_tx_sched: table of IDLE selection vectors plus
// hand-written multi-cycle sequences (gap timing, priority, backpressure,
// stop, abort, reset, counter wrap).
module tb_enet_tx_sched;

    localparam int IFG = 24;
    localparam int CW  = 4;

    logic          tx_clk = 1'b0;
    logic          rst;
    logic          en, gts, rfc, tfc, ps, psz, dreq;
    logic          gnt, pms, pmsz, stop;
    logic [CW-1:0] stat;
    logic [CW-1:0] exp_frames;

    int n_chk  = 0;
    int n_pass = 0;

    enet_tx_sched_if mif ();

    enet_tx_sched #(.IFG_CYC(IFG), .CNT_W(CW)) dut (
        .tx_clk               (tx_clk),
        .rst                  (rst),
        .i_ether_en           (en),
        .i_gts                (gts),
        .i_rfc_pause          (rfc),
        .i_tfc_pause          (tfc),
        .i_pause_send         (ps),
        .i_pause_send_zero    (psz),
        .i_data_req           (dreq),
        .o_data_gnt           (gnt),
        .o_pause_mac_send     (pms),
        .o_pause_mac_send_zero(pmsz),
        .o_tx_mac_stop        (stop),
        .o_stat_frames        (stat),
        .mac                  (mif)
    );

    always #5 tx_clk = ~tx_clk;

    typedef struct {
        logic       en, gts, rfc, tfc, ps, psz, dreq;
        logic       ev;
        logic [1:0] et;
        logic       es;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Advance past one rising edge and settle well clear of it.
    task automatic step();
        @(posedge tx_clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; gts = 0; rfc = 0; tfc = 0; ps = 0; psz = 0; dreq = 0;
        mif.mac_start_ready = 1'b0;
        mif.mac_done        = 1'b0;
        step();
        rst = 1'b0;
        exp_frames = '0;
    endtask

    // Wait for a start (ready already high), check type/ack, then complete it.
    // n is the number of rising edges waited, starting from the current cycle.
    task automatic run_frame(input logic [1:0] et, input string nm, output int n);
        logic [2:0] eack;
        n = 0;
        while (!mif.mac_start_valid && n < 60) begin
            step();
            n++;
        end
        eack = (et == 2'b00) ? 3'b100 : (et == 2'b01) ? 3'b010 : 3'b001;
        #1;
        chk({nm, "_valid"}, 16'(mif.mac_start_valid), 16'd1);
        chk({nm, "_type"},  16'(mif.mac_type), 16'(et));
        chk({nm, "_ack"},   16'({gnt, pms, pmsz}), 16'(eack));
        exp_frames = exp_frames + 1'b1;
        step();
        chk({nm, "_ack_once"}, 16'({gnt, pms, pmsz, mif.mac_start_valid}), 16'd0);
        chk({nm, "_stat"},     16'(stat), 16'(exp_frames));
        mif.mac_done = 1'b1;
        step();
        mif.mac_done = 1'b0;
    endtask

    initial begin
        int n;
        int bad;

        //               en gts rfc tfc ps psz dreq  ev  et    es
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 1,  1, 2'b00, 0};
        tbl[2]  = '{1, 0, 0, 0, 1, 0, 0,  1, 2'b01, 0};
        tbl[3]  = '{1, 0, 0, 1, 0, 0, 0,  1, 2'b01, 0};
        tbl[4]  = '{1, 0, 0, 0, 0, 1, 0,  1, 2'b10, 0};
        tbl[5]  = '{1, 0, 0, 0, 1, 1, 1,  1, 2'b01, 0};
        tbl[6]  = '{1, 0, 0, 0, 0, 1, 1,  1, 2'b10, 0};
        tbl[7]  = '{1, 0, 1, 0, 0, 0, 1,  0, 2'b00, 1};
        tbl[8]  = '{1, 0, 1, 1, 0, 0, 1,  1, 2'b01, 1};
        tbl[9]  = '{1, 1, 0, 1, 1, 1, 1,  0, 2'b00, 1};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 0};
        tbl[11] = '{1, 1, 1, 0, 0, 0, 0,  0, 2'b00, 1};

        // Reset state
        do_reset();
        chk("rst_valid", 16'(mif.mac_start_valid), 16'd0);
        chk("rst_type",  16'(mif.mac_type), 16'd0);
        chk("rst_abort", 16'(mif.mac_abort), 16'd0);
        chk("rst_stop",  16'(stop), 16'd0);
        chk("rst_stat",  16'(stat), 16'd0);
        chk("rst_acks",  16'({gnt, pms, pmsz}), 16'd0);

        // IDLE candidate selection / blocking table
        for (int i = 0; i < 12; i++) begin
            do_reset();
            en = tbl[i].en; gts = tbl[i].gts; rfc = tbl[i].rfc; tfc = tbl[i].tfc;
            ps = tbl[i].ps; psz = tbl[i].psz; dreq = tbl[i].dreq;
            step();
            chk($sformatf("tbl%0d_valid", i), 16'(mif.mac_start_valid), 16'(tbl[i].ev));
            chk($sformatf("tbl%0d_type", i),  16'(mif.mac_type), 16'(tbl[i].et));
            chk($sformatf("tbl%0d_stop", i),  16'(stop), 16'(tbl[i].es));
        end

        // Idle data frame and inter-frame gap
        do_reset();
        dreq = 1; mif.mac_start_ready = 1;
        run_frame(2'b00, "d1", n);
        chk("d1_latency", 16'(n), 16'd1);
        run_frame(2'b00, "d2", n);
        chk("ifg_gap", 16'(n + 1), 16'(IFG + 1));
        dreq = 0;

        // Priority pause > zero-pause > data
        do_reset();
        ps = 1; psz = 1; dreq = 1; mif.mac_start_ready = 1;
        run_frame(2'b01, "pri_p", n);
        ps = 0;
        run_frame(2'b10, "pri_z", n);
        psz = 0;
        run_frame(2'b00, "pri_d", n);
        dreq = 0;

        // Backpressure: start held while ready low, request dropped mid-wait
        do_reset();
        ps = 1;
        step();
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("bp%0d_valid", i), 16'(mif.mac_start_valid), 16'd1);
            chk($sformatf("bp%0d_type", i),  16'(mif.mac_type), 16'd1);
            chk($sformatf("bp%0d_ack", i),   16'({gnt, pms, pmsz}), 16'd0);
            if (i == 2) ps = 0;
            step();
        end
        mif.mac_start_ready = 1; #1;
        chk("bp_ack", 16'({gnt, pms, pmsz}), 16'b010);
        step();
        chk("bp_ack_once", 16'({gnt, pms, pmsz, mif.mac_start_valid}), 16'd0);
        chk("bp_stat", 16'(stat), 16'd1);

        // Stop: peer pause blocks data, pause frame still goes, gts in SEND
        do_reset();
        rfc = 1; dreq = 1; mif.mac_start_ready = 1;
        step();
        chk("stop_blk_valid", 16'(mif.mac_start_valid), 16'd0);
        chk("stop_rise", 16'(stop), 16'd1);
        tfc = 1;
        step();
        chk("stop_p_type", 16'(mif.mac_type), 16'd1);
        chk("stop_p_ack",  16'(pms), 16'd1);
        tfc = 0;
        step();
        chk("stop_fall_send", 16'(stop), 16'd0);
        gts = 1; mif.mac_done = 1;
        step();
        mif.mac_done = 0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (mif.mac_start_valid) bad++;
            step();
        end
        chk("stop_gts_nostart", 16'(bad), 16'd0);
        chk("stop_after_gap", 16'(stop), 16'd1);
        chk("stop_stat", 16'(stat), 16'd1);
        gts = 0; rfc = 0;
        step();
        chk("stop_release", 16'(stop), 16'd0);
        chk("stop_release_valid", 16'(mif.mac_start_valid), 16'd1);

        // Abort in SEND, gap still enforced; ether_en drop in REQ; reset in REQ
        do_reset();
        dreq = 1; mif.mac_start_ready = 1;
        step();
        chk("ab_gnt", 16'(gnt), 16'd1);
        dreq = 0;
        step();
        en = 0;
        step();
        chk("ab_pulse", 16'(mif.mac_abort), 16'd1);
        en = 1; dreq = 1;
        step();
        chk("ab_pulse_once", 16'(mif.mac_abort), 16'd0);
        n = 2;
        while (!mif.mac_start_valid && n < 60) begin
            step();
            n++;
        end
        chk("ab_gap", 16'(n), 16'(IFG + 1));
        mif.mac_start_ready = 0;
        step();
        chk("req_hold", 16'(mif.mac_start_valid), 16'd1);
        en = 0; mif.mac_start_ready = 1; #1;
        chk("req_en_off_gnt", 16'(gnt), 16'd0);
        step();
        chk("req_en_off_valid", 16'(mif.mac_start_valid), 16'd0);
        chk("req_en_off_stat", 16'(stat), 16'd1);
        en = 1; mif.mac_start_ready = 0;
        step();
        chk("req_again", 16'(mif.mac_start_valid), 16'd1);
        rst = 1;
        step();
        rst = 0;
        chk("rstreq_valid", 16'(mif.mac_start_valid), 16'd0);
        chk("rstreq_type",  16'(mif.mac_type), 16'd0);
        chk("rstreq_stat",  16'(stat), 16'd0);
        chk("rstreq_stop",  16'(stop), 16'd0);
        chk("rstreq_acks",  16'({gnt, pms, pmsz, mif.mac_abort}), 16'd0);

        // Statistics counter wrap (CNT_W = 4)
        do_reset();
        dreq = 1; mif.mac_start_ready = 1;
        for (int i = 0; i < 17; i++) run_frame(2'b00, $sformatf("wr%0d", i), n);
        chk("wrap_final", 16'(stat), 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
